record_packer: RTL and testbench
================================

RECORD_PACKER -- requirements
Module: record_packer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning FIFO depth in records (power of two, 4..64).
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 Port reset_n SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-004 Port record_rdy SHALL be an input, 1 bit wide: single-cycle strobe marking a valid record.
REQ-005 Port record SHALL be an input, 47 bits wide: the tagged event record, sampled when record_rdy=1.
REQ-006 Port clear_lost SHALL be an input, 1 bit wide: synchronous clear of lost_count and overflow.
REQ-007 Port byte_data SHALL be an output, 8 bits wide: the outgoing byte stream.
REQ-008 Port byte_valid SHALL be an output, 1 bit wide: byte_data holds a valid byte.
REQ-009 Port byte_ready SHALL be an input, 1 bit wide: the sink accepts the byte.
REQ-010 Port fifo_level SHALL be an output, log2(DEPTH)+1 bits wide: the number of records stored.
REQ-011 Port lost_count SHALL be an output, 16 bits wide: records dropped on overflow, saturating.
REQ-012 Port overflow SHALL be an output, 1 bit wide: sticky flag set on any drop.

Function
REQ-013 A record SHALL be written to the FIFO on a cycle with record_rdy=1 when the FIFO is not full, or is full and a pop occurs in the same cycle.
REQ-014 When record_rdy=1, the FIFO is full and no pop occurs, the record SHALL be dropped, lost_count SHALL increment (holding at 16'hFFFF), and overflow SHALL be set.
REQ-015 clear_lost=1 SHALL zero lost_count and overflow next cycle; a simultaneous drop SHALL leave lost_count=1 and overflow=1.
REQ-016 fifo_level SHALL equal writes minus pops, updating the cycle after each event; a simultaneous write and pop SHALL leave it unchanged.
REQ-017 The FSM SHALL have two states: IDLE (byte_valid=0) and SEND (byte_valid=1), with a 3-bit byte index 0..5.
REQ-018 In IDLE with fifo_level>0, the block SHALL pop the head into a 48-bit shift register {1'b0, record} and enter SEND with index 0.
REQ-019 Byte k SHALL be bits [8k+7:8k] of the shift register, k=0..5, LSB first; byte 5 bit 7 SHALL always be 0.
REQ-020 In SEND, when byte_valid=1 and byte_ready=1 (handshake) and index<5, the index SHALL increment.
REQ-021 A handshake at index 5 with the FIFO non-empty SHALL pop and load the next record in the same cycle, staying in SEND with index 0 and no bubble.
REQ-022 A handshake at index 5 with the FIFO empty SHALL return the FSM to IDLE.
REQ-023 While byte_valid=1 and byte_ready=0, byte_data and byte_valid SHALL hold stable.
REQ-024 Minimum latency SHALL be: record_rdy at cycle N gives byte 0 valid at cycle N+2 when idle and empty.
REQ-025 Sustained throughput SHALL be one byte per cycle while byte_ready=1.

Reset
REQ-026 While reset_n=0, the block SHALL hold FSM=IDLE, index=0, byte_valid=0, byte_data=0, fifo_level=0, lost_count=0, overflow=0 and FIFO pointers at 0.
REQ-027 Reset mid-operation SHALL discard the in-flight and queued records without counting them in lost_count.
REQ-028 The first write SHALL be accepted on the first rising edge after reset_n deasserts.

Verification
REQ-029 The bench SHALL cover: one record 47'h1234_5678_9ABC with byte_ready=1 -> bytes BC,9A,78,56,34,12 on cycles N+2..N+7, then byte_valid=0.
REQ-030 The bench SHALL cover: record 47'h7FFF_FFFF_FFFF -> byte 5 = 8'h7F, all others FF.
REQ-031 The bench SHALL cover: byte_ready=0 for 20 cycles while 20 records strobe (DEPTH=16) -> one record in the shift register, fifo_level=16, lost_count=3, overflow=1; then clear_lost -> both zero.
REQ-032 The bench SHALL cover: two records back-to-back with byte_ready=1 -> 12 consecutive valid bytes with no gap.
REQ-033 The bench SHALL cover: with the FIFO full, record_rdy coinciding with the index-5 handshake -> record accepted, lost_count unchanged, fifo_level unchanged.
REQ-034 The bench SHALL cover: reset_n pulsed low during byte 3 of a record -> byte_valid=0 and fifo_level=0 asynchronously, lost_count=0, and the next record emits byte 0 normally.

Source files
------------

// File: rtl/record_packer.sv
// Record packer: queues 47-bit event records in a FIFO and serialises each one
// as six bytes, LSB first, over a valid/ready byte stream. Drops are counted.
module record_packer #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     record_rdy,
  input  logic [46:0]              record,
  input  logic                     clear_lost,
  output logic [7:0]               byte_data,
  output logic                     byte_valid,
  input  logic                     byte_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              lost_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t         state;
  logic [2:0]     idx;
  logic [47:0]    shreg;
  logic [46:0]    mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;

  logic empty;
  logic full;
  logic hs;
  logic pop;
  logic wr;
  logic drop;

  assign empty = (fifo_level == '0);
  assign full  = (fifo_level == FULL_LEVEL);
  assign hs    = byte_valid && byte_ready;
  // The head is consumed either to start from idle or to chain straight on
  // from the last byte of the current record, so the stream has no bubble.
  assign pop   = !empty && ((state == IDLE) || (hs && idx == 3'd5));
  assign wr    = record_rdy && (!full || pop);
  assign drop  = record_rdy && full && !pop;

  // The current byte is always the low byte of the shift register.
  assign byte_data = shreg[7:0];

  // NOTE: the storage array has no reset; pointers and level define which
  // entries are meaningful, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= record;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      case ({wr, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
    end else if (pop) begin
      state      <= SEND;
      idx        <= '0;
      shreg      <= {1'b0, mem[rptr]};
      byte_valid <= 1'b1;
    end else if (state == SEND && hs) begin
      if (idx == 3'd5) begin
        state      <= IDLE;
        idx        <= '0;
        byte_valid <= 1'b0;
      end else begin
        idx   <= idx + 1'b1;
        shreg <= {8'h00, shreg[47:8]};
      end
    end
  end

  // A drop coinciding with a clear survives as a single counted loss.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lost_count <= '0;
      overflow   <= 1'b0;
    end else if (clear_lost) begin
      lost_count <= drop ? 16'd1 : 16'd0;
      overflow   <= drop;
    end else if (drop) begin
      if (lost_count != 16'hFFFF) lost_count <= lost_count + 1'b1;
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_record_packer.sv
// Self-checking bench for record_packer: directed scenarios plus randomized
// traffic compared cycle by cycle against a queue-based reference model.
module tb_record_packer;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          record_rdy = 1'b0;
  logic [46:0]   record = '0;
  logic          clear_lost = 1'b0;
  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          byte_ready = 1'b0;
  logic [LW-1:0] fifo_level;
  logic [15:0]   lost_count;
  logic          overflow;

  record_packer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .record_rdy (record_rdy),
    .record     (record),
    .clear_lost (clear_lost),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .fifo_level (fifo_level),
    .lost_count (lost_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: queue of accepted records, the record being sent and
  // how many of its six bytes are still to go.
  logic [46:0] mq[$];
  logic [47:0] m_cur;
  int          m_rem;
  int          m_lost;
  bit          m_ovf;

  logic [7:0]  obs_b[$];
  int          obs_c[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_cur  = '0;
    m_rem  = 0;
    m_lost = 0;
    m_ovf  = 0;
  endtask

  task automatic obs_clear();
    obs_b.delete();
    obs_c.delete();
  endtask

  function automatic logic [46:0] rnd_rec();
    return {15'($urandom), 32'($urandom)};
  endfunction

  // One clock cycle: drive inputs, compare outputs with the model, advance.
  task automatic step(input bit rdy, input logic [46:0] rec, input bit brdy, input bit clr);
    bit hs, pop, full, wr, drop;
    record_rdy = rdy;
    record     = rec;
    byte_ready = brdy;
    clear_lost = clr;

    check("valid", 64'(byte_valid), 64'(m_rem > 0));
    if (m_rem > 0) check("data", 64'(byte_data), 64'(m_cur[8*(6-m_rem) +: 8]));
    check("level", 64'(fifo_level), 64'(mq.size()));
    check("lost", 64'(lost_count), 64'(m_lost));
    check("ovf", 64'(overflow), 64'(m_ovf));
    if (byte_valid && byte_ready) begin
      obs_b.push_back(byte_data);
      obs_c.push_back(cyc);
    end

    hs   = (m_rem > 0) && brdy;
    pop  = (mq.size() > 0) && (m_rem == 0 || (hs && m_rem == 1));
    full = (mq.size() == DEPTH);
    wr   = rdy && (!full || pop);
    drop = rdy && full && !pop;
    if (pop) begin
      m_cur = {1'b0, mq.pop_front()};
      m_rem = 6;
    end else if (hs) begin
      m_rem--;
    end
    if (wr) mq.push_back(rec);
    if (clr) begin
      m_lost = drop ? 1 : 0;
      m_ovf  = drop;
    end else if (drop) begin
      if (m_lost < 65535) m_lost++;
      m_ovf = 1;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  exp_a [6];
    logic [46:0] ra, rb, rx, rw;
    int          n;
    int          p_rdy, p_brdy;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(byte_valid), 64'(0));
    check("rst_data", 64'(byte_data), 64'(0));
    check("rst_level", 64'(fifo_level), 64'(0));
    check("rst_lost", 64'(lost_count), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    reset_n = 1'b1;

    // First record right after reset, byte order and latency.
    obs_clear();
    n = cyc;
    step(1'b1, 47'h1234_5678_9ABC, 1'b1, 1'b0);
    idle_steps(8);
    exp_a = '{8'hBC, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12};
    check("basic_count", 64'(obs_b.size()), 64'(6));
    if (obs_b.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check("basic_byte", 64'(obs_b[i]), 64'(exp_a[i]));
        check("basic_cycle", 64'(obs_c[i]), 64'(n + 2 + i));
      end
    end
    check("basic_idle", 64'(byte_valid), 64'(0));

    // All-ones record: top bit of the last byte is the pad zero.
    obs_clear();
    step(1'b1, 47'h7FFF_FFFF_FFFF, 1'b1, 1'b0);
    idle_steps(8);
    exp_a = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
    check("ones_count", 64'(obs_b.size()), 64'(6));
    if (obs_b.size() == 6)
      for (int i = 0; i < 6; i++) check("ones_byte", 64'(obs_b[i]), 64'(exp_a[i]));

    // Stalled sink with 20 strobes: one record loaded, 16 queued, 3 lost.
    ra = 47'h0123_4567_89AB;
    step(1'b1, ra, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) step(1'b1, rnd_rec(), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("ovf_level", 64'(fifo_level), 64'(16));
    check("ovf_lost", 64'(lost_count), 64'(3));
    check("ovf_flag", 64'(overflow), 64'(1));
    check("ovf_head", 64'(byte_data), 64'(8'hAB));
    step(1'b1, rnd_rec(), 1'b0, 1'b1);
    check("clr_drop_lost", 64'(lost_count), 64'(1));
    check("clr_drop_ovf", 64'(overflow), 64'(1));
    step(1'b0, '0, 1'b0, 1'b1);
    check("clr_lost", 64'(lost_count), 64'(0));
    check("clr_ovf", 64'(overflow), 64'(0));

    // Full FIFO, write on the index-5 handshake: accepted, nothing lost.
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, rnd_rec(), 1'b1, 1'b0);
    check("full_hs_level", 64'(fifo_level), 64'(16));
    check("full_hs_lost", 64'(lost_count), 64'(0));
    check("full_hs_valid", 64'(byte_valid), 64'(1));
    idle_steps(17 * 6 + 4);
    check("drain_level", 64'(fifo_level), 64'(0));
    check("drain_valid", 64'(byte_valid), 64'(0));

    // Two records back to back: twelve bytes with no gap.
    obs_clear();
    ra = rnd_rec();
    rb = rnd_rec();
    n = cyc;
    step(1'b1, ra, 1'b1, 1'b0);
    step(1'b1, rb, 1'b1, 1'b0);
    idle_steps(14);
    check("b2b_count", 64'(obs_b.size()), 64'(12));
    if (obs_b.size() == 12) begin
      check("b2b_first", 64'(obs_c[0]), 64'(n + 2));
      check("b2b_span", 64'(obs_c[11] - obs_c[0]), 64'(11));
      check("b2b_a0", 64'(obs_b[0]), 64'(ra[7:0]));
      check("b2b_b0", 64'(obs_b[6]), 64'(rb[7:0]));
      check("b2b_b5", 64'(obs_b[11]), 64'({1'b0, rb[46:40]}));
    end

    // Reset while byte 3 of a record is on the bus, with more queued behind.
    rx = rnd_rec();
    step(1'b1, rx, 1'b1, 1'b0);
    step(1'b1, rnd_rec(), 1'b1, 1'b0);
    step(1'b1, rnd_rec(), 1'b1, 1'b0);
    for (int i = 0; i < 20 && m_rem != 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("mid_byte3", 64'(byte_data), 64'(rx[31:24]));
    reset_n = 1'b0;
    #1;
    check("async_valid", 64'(byte_valid), 64'(0));
    check("async_level", 64'(fifo_level), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    check("async_lost", 64'(lost_count), 64'(0));
    reset_n = 1'b1;
    obs_clear();
    rw = rnd_rec();
    n = cyc;
    step(1'b1, rw, 1'b1, 1'b0);
    idle_steps(8);
    check("post_rst_count", 64'(obs_b.size()), 64'(6));
    if (obs_b.size() == 6) begin
      check("post_rst_b0", 64'(obs_b[0]), 64'(rw[7:0]));
      check("post_rst_cycle", 64'(obs_c[0]), 64'(n + 2));
    end

    // Randomized traffic in phases of differing load and back-pressure.
    for (int ph = 0; ph < 6; ph++) begin
      p_rdy  = $urandom_range(5, 90);
      p_brdy = $urandom_range(5, 100);
      for (int i = 0; i < 500; i++)
        step($urandom_range(0, 99) < p_rdy, rnd_rec(),
             $urandom_range(0, 99) < p_brdy, $urandom_range(0, 149) == 0);
    end
    idle_steps(17 * 6 + 4);
    check("final_level", 64'(fifo_level), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
